// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and lane helpers for the stream serializer/deserializer pair
package stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } stream_state_t;

    // Bit offset of a lane inside a packed multi-lane word.
    function automatic int lane_lsb(input int lane, input int data_width);
        return lane * data_width;
    endfunction

endpackage

// File: rtl/stream_serializer.sv
// rtl/stream_serializer.sv - wide-to-narrow valid/ready serializer, lane 0 first, last beat flagged
module stream_serializer
    import stream_pkg::*;
#(
    parameter int LANE_COUNT_WIDTH = 2,
    parameter int DATA_WIDTH       = 16
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic                                           in_valid,
    input  logic [(1 << LANE_COUNT_WIDTH)*DATA_WIDTH-1:0]  in_data,
    input  logic [LANE_COUNT_WIDTH:0]                      in_count,
    output logic                                           in_ready,
    output logic                                           out_valid,
    output logic [DATA_WIDTH-1:0]                          out_data,
    output logic                                           out_last,
    input  logic                                           out_ready
);

    localparam int LANES = 1 << LANE_COUNT_WIDTH;
    localparam logic [LANE_COUNT_WIDTH:0] LANES_CNT = (LANE_COUNT_WIDTH + 1)'(LANES);

    stream_state_t                 state, state_n;
    logic [LANE_COUNT_WIDTH-1:0]   lane_idx, lane_n;
    logic [LANE_COUNT_WIDTH-1:0]   last_lane, last_n;
    logic [LANES*DATA_WIDTH-1:0]   hold, hold_n;
    logic                          valid_n;
    logic                          last_flag_n;
    logic [DATA_WIDTH-1:0]         data_n;
    logic [LANE_COUNT_WIDTH:0]     eff_count;
    logic                          beat_taken;
    logic                          load;

    always_comb begin
        eff_count = (in_count > LANES_CNT) ? LANES_CNT : in_count;
    end

    assign beat_taken = out_valid && out_ready;
    // Ready in SEND depends only on the last beat leaving, never on in_valid.
    assign in_ready   = !reset && (state == IDLE || (beat_taken && out_last));
    assign load       = in_valid && in_ready && (eff_count != '0);

    always_comb begin
        state_n     = state;
        lane_n      = lane_idx;
        last_n      = last_lane;
        hold_n      = hold;
        valid_n     = out_valid;
        data_n      = out_data;
        last_flag_n = out_last;
        if (load) begin
            state_n     = SEND;
            hold_n      = in_data;
            lane_n      = '0;
            last_n      = eff_count[LANE_COUNT_WIDTH-1:0] - 1'b1;
            valid_n     = 1'b1;
            data_n      = in_data[DATA_WIDTH-1:0];
            last_flag_n = (last_n == '0);
        end else if (state == SEND && beat_taken) begin
            if (out_last) begin
                state_n     = IDLE;
                valid_n     = 1'b0;
                last_flag_n = 1'b0;
            end else begin
                lane_n      = lane_idx + 1'b1;
                data_n      = hold[lane_lsb(int'(lane_n), DATA_WIDTH) +: DATA_WIDTH];
                last_flag_n = (lane_n == last_lane);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lane_idx  <= '0;
            last_lane <= '0;
            hold      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_n;
            lane_idx  <= lane_n;
            last_lane <= last_n;
            hold      <= hold_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            out_last  <= last_flag_n;
        end
    end

endmodule
